// File: rtl/gps_sentence_ctrl.sv
// NMEA sentence write sequencer: frames '$'..'*hh' CR LF sentences from the UART
// byte stream, stores body bytes into one bank of a 2 x 64 x 8 buffer, verifies
// the XOR checksum and hands completed banks to the reader with ready/ack.
module gps_sentence_ctrl #(
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned SYNC_STAGES = 3
) (
   input  logic       clock_50mhz,
   input  logic       reset_n,
   input  logic       data_valid,
   input  logic [7:0] data,
   output logic       wr_en,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_ready,
   output logic       frame_bank,
   output logic [6:0] frame_len,
   input  logic       frame_ack,
   output logic [7:0] good_count,
   output logic [7:0] drop_count,
   output logic [2:0] err_pulse
);

   localparam int unsigned OFF_W  = 7;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ERR_W  = 3;

   localparam logic [BYTE_W-1:0] CH_DOLLAR = 8'h24;
   localparam logic [BYTE_W-1:0] CH_STAR   = 8'h2A;
   localparam logic [BYTE_W-1:0] CH_CR     = 8'h0D;
   localparam logic [BYTE_W-1:0] CH_LF     = 8'h0A;

   localparam logic [ERR_W-1:0] ERR_CSUM = 3'b001;
   localparam logic [ERR_W-1:0] ERR_OVF  = 3'b010;
   localparam logic [ERR_W-1:0] ERR_BUSY = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BODY,
      S_CSUM_HI,
      S_CSUM_LO,
      S_EOL
   } state_e;

   // Synchroniser and edge detect
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   strobe_c;

   // Sentence framing state
   state_e             state_q, state_d;
   logic               fill_q, fill_d;
   logic [OFF_W-1:0]   offset_q, offset_d;
   logic [BYTE_W-1:0]  csum_q, csum_d;
   logic [3:0]         hi_q, hi_d;

   // Coincident ack/completion holding slot
   logic               pend_q, pend_d;
   logic               pend_bank_q, pend_bank_d;
   logic [OFF_W-1:0]   pend_len_q, pend_len_d;

   // Registered outputs
   logic               wr_en_q, wr_en_d;
   logic [6:0]         wr_addr_q, wr_addr_d;
   logic [BYTE_W-1:0]  wr_data_q, wr_data_d;
   logic               frame_ready_q, frame_ready_d;
   logic               frame_bank_q, frame_bank_d;
   logic [OFF_W-1:0]   frame_len_q, frame_len_d;
   logic [BYTE_W-1:0]  good_count_q, good_count_d;
   logic [BYTE_W-1:0]  drop_count_q, drop_count_d;
   logic [ERR_W-1:0]   err_pulse_q, err_pulse_d;

   logic               hex_ok_c;
   logic [3:0]         hex_nib_c;
   logic               ack_c;

   // Shift the asynchronous strobe through the chain; edge on the last stage
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], data_valid};
      prev_d   = sync_q[SYNC_STAGES-1];
      strobe_c = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   // Uppercase hex digit decode of the incoming byte
   always_comb begin
      hex_ok_c  = 1'b0;
      hex_nib_c = 4'h0;
      if (data >= 8'h30 && data <= 8'h39) begin
         hex_ok_c  = 1'b1;
         hex_nib_c = 4'(data - 8'h30);
      end else if (data >= 8'h41 && data <= 8'h46) begin
         hex_ok_c  = 1'b1;
         hex_nib_c = 4'(data - 8'h37);
      end
   end

   // Next-state: framing FSM, buffer writes, frame handoff and counters
   always_comb begin
      state_d       = state_q;
      fill_d        = fill_q;
      offset_d      = offset_q;
      csum_d        = csum_q;
      hi_d          = hi_q;
      pend_d        = pend_q;
      pend_bank_d   = pend_bank_q;
      pend_len_d    = pend_len_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_ready_d = frame_ready_q;
      frame_bank_d  = frame_bank_q;
      frame_len_d   = frame_len_q;
      good_count_d  = good_count_q;
      drop_count_d  = drop_count_q;
      err_pulse_d   = '0;

      ack_c = frame_ack & frame_ready_q;
      if (ack_c) begin
         frame_ready_d = 1'b0;
      end

      // A frame completed alongside an ack is presented once the old one is gone
      if (pend_q && !frame_ready_q) begin
         frame_ready_d = 1'b1;
         frame_bank_d  = pend_bank_q;
         frame_len_d   = pend_len_q;
         pend_d        = 1'b0;
      end

      if (strobe_c) begin
         case (state_q)
            S_IDLE: begin
               if (data == CH_DOLLAR) begin
                  state_d  = S_BODY;
                  offset_d = '0;
                  csum_d   = '0;
               end
            end
            S_BODY: begin
               if (data == CH_STAR) begin
                  state_d = S_CSUM_HI;
               end else if (data == CH_DOLLAR) begin
                  drop_count_d = drop_count_q + 8'd1;
                  err_pulse_d  = ERR_CSUM;
                  offset_d     = '0;
                  csum_d       = '0;
               end else if (offset_q == OFF_W'(MAX_LEN)) begin
                  drop_count_d = drop_count_q + 8'd1;
                  err_pulse_d  = ERR_OVF;
                  state_d      = S_IDLE;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {fill_q, offset_q[5:0]};
                  wr_data_d = data;
                  csum_d    = csum_q ^ data;
                  offset_d  = offset_q + OFF_W'(1);
               end
            end
            S_CSUM_HI: begin
               if (hex_ok_c) begin
                  hi_d    = hex_nib_c;
                  state_d = S_CSUM_LO;
               end else begin
                  drop_count_d = drop_count_q + 8'd1;
                  err_pulse_d  = ERR_CSUM;
                  state_d      = S_IDLE;
               end
            end
            S_CSUM_LO: begin
               // An empty body is never delivered, so frame_len is always >= 1
               if (hex_ok_c && {hi_q, hex_nib_c} == csum_q && offset_q != '0) begin
                  state_d = S_EOL;
               end else begin
                  drop_count_d = drop_count_q + 8'd1;
                  err_pulse_d  = ERR_CSUM;
                  state_d      = S_IDLE;
               end
            end
            S_EOL: begin
               if (data == CH_LF) begin
                  state_d = S_IDLE;
                  if (!frame_ready_q) begin
                     frame_ready_d = 1'b1;
                     frame_bank_d  = fill_q;
                     frame_len_d   = offset_q;
                     fill_d        = ~fill_q;
                     good_count_d  = good_count_q + 8'd1;
                  end else if (ack_c) begin
                     pend_d       = 1'b1;
                     pend_bank_d  = fill_q;
                     pend_len_d   = offset_q;
                     fill_d       = ~fill_q;
                     good_count_d = good_count_q + 8'd1;
                  end else begin
                     // Reader still owns the other bank; this fill bank gets reused
                     drop_count_d = drop_count_q + 8'd1;
                     err_pulse_d  = ERR_BUSY;
                  end
               end else if (data != CH_CR) begin
                  drop_count_d = drop_count_q + 8'd1;
                  err_pulse_d  = ERR_CSUM;
                  state_d      = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clock_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         sync_q        <= '0;
         prev_q        <= 1'b0;
         state_q       <= S_IDLE;
         fill_q        <= 1'b0;
         offset_q      <= '0;
         csum_q        <= '0;
         hi_q          <= '0;
         pend_q        <= 1'b0;
         pend_bank_q   <= 1'b0;
         pend_len_q    <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_ready_q <= 1'b0;
         frame_bank_q  <= 1'b0;
         frame_len_q   <= '0;
         good_count_q  <= '0;
         drop_count_q  <= '0;
         err_pulse_q   <= '0;
      end else begin
         sync_q        <= sync_d;
         prev_q        <= prev_d;
         state_q       <= state_d;
         fill_q        <= fill_d;
         offset_q      <= offset_d;
         csum_q        <= csum_d;
         hi_q          <= hi_d;
         pend_q        <= pend_d;
         pend_bank_q   <= pend_bank_d;
         pend_len_q    <= pend_len_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_ready_q <= frame_ready_d;
         frame_bank_q  <= frame_bank_d;
         frame_len_q   <= frame_len_d;
         good_count_q  <= good_count_d;
         drop_count_q  <= drop_count_d;
         err_pulse_q   <= err_pulse_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_ready = frame_ready_q;
   assign frame_bank  = frame_bank_q;
   assign frame_len   = frame_len_q;
   assign good_count  = good_count_q;
   assign drop_count  = drop_count_q;
   assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_gps_sentence_ctrl.sv
// Directed bench for gps_sentence_ctrl: sentences are sent byte by byte through
// the asynchronous strobe and results are compared against hand-derived values.
module tb_gps_sentence_ctrl;

   logic       clk;
   logic       rst_n;
   logic       data_valid;
   logic [7:0] data;
   logic       wr_en;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_ready;
   logic       frame_bank;
   logic [6:0] frame_len;
   logic       frame_ack;
   logic [7:0] good_count;
   logic [7:0] drop_count;
   logic [2:0] err_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   // Monitor records (written only by the monitor process)
   logic [6:0] wr_addr_log[$];
   logic [7:0] wr_data_log[$];
   int         n_err_csum = 0;
   int         n_err_ovf  = 0;
   int         n_err_busy = 0;
   int         n_err_long = 0;
   logic [2:0] err_prev   = 3'b000;

   gps_sentence_ctrl dut (
      .clock_50mhz (clk),
      .reset_n     (rst_n),
      .data_valid  (data_valid),
      .data        (data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_ready (frame_ready),
      .frame_bank  (frame_bank),
      .frame_len   (frame_len),
      .frame_ack   (frame_ack),
      .good_count  (good_count),
      .drop_count  (drop_count),
      .err_pulse   (err_pulse)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Log writes and error pulses on the inactive edge
   always @(negedge clk) begin
      if (wr_en) begin
         wr_addr_log.push_back(wr_addr);
         wr_data_log.push_back(wr_data);
      end
      if (err_pulse[0]) n_err_csum = n_err_csum + 1;
      if (err_pulse[1]) n_err_ovf  = n_err_ovf + 1;
      if (err_pulse[2]) n_err_busy = n_err_busy + 1;
      if (err_pulse != 3'b000 && err_prev != 3'b000) n_err_long = n_err_long + 1;
      err_prev = err_pulse;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_bad = n_bad + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      data       = b;
      data_valid = 1'b1;
      repeat (6) @(negedge clk);
      data_valid = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(8'(s[i]));
      end
   endtask

   task automatic ack_frame();
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int base;
      int n0;
      data_valid = 1'b0;
      data       = 8'h00;
      frame_ack  = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_wr_en",  32'(wr_en), 32'd0);
      check("rst_addr",   32'(wr_addr), 32'd0);
      check("rst_data",   32'(wr_data), 32'd0);
      check("rst_ready",  32'(frame_ready), 32'd0);
      check("rst_bank",   32'(frame_bank), 32'd0);
      check("rst_len",    32'(frame_len), 32'd0);
      check("rst_good",   32'(good_count), 32'd0);
      check("rst_drop",   32'(drop_count), 32'd0);
      check("rst_err",    32'(err_pulse), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Good sentence: body "GPGGA,12" XOR = 0x79
      base = wr_addr_log.size();
      send_str("$GPGGA,12*79\r\n");
      check("g1_nwr", 32'(wr_addr_log.size() - base), 32'd8);
      for (int i = 0; i < 8; i++) check("g1_addr", 32'(wr_addr_log[base + i]), 32'(i));
      check("g1_d0",    32'(wr_data_log[base]), 32'h47);
      check("g1_d7",    32'(wr_data_log[base + 7]), 32'h32);
      check("g1_ready", 32'(frame_ready), 32'd1);
      check("g1_bank",  32'(frame_bank), 32'd0);
      check("g1_len",   32'(frame_len), 32'd8);
      check("g1_good",  32'(good_count), 32'd1);
      check("g1_drop",  32'(drop_count), 32'd0);

      // Ack clears ready, bank/len hold
      ack_frame();
      check("ack_ready", 32'(frame_ready), 32'd0);
      check("ack_bank",  32'(frame_bank), 32'd0);
      check("ack_len",   32'(frame_len), 32'd8);

      // Wrong checksum: writes go to bank 1, checksum drop
      base = wr_addr_log.size();
      send_str("$GPGGA,12*78\r\n");
      check("bad_nwr",   32'(wr_addr_log.size() - base), 32'd8);
      check("bad_addr0", 32'(wr_addr_log[base]), 32'd64);
      check("bad_ready", 32'(frame_ready), 32'd0);
      check("bad_drop",  32'(drop_count), 32'd1);
      check("bad_ecs",   32'(n_err_csum), 32'd1);
      check("bad_good",  32'(good_count), 32'd1);

      // Good sentence after ack lands in bank 1
      send_str("$GPGGA,12*79\r\n");
      check("g2_ready", 32'(frame_ready), 32'd1);
      check("g2_bank",  32'(frame_bank), 32'd1);
      check("g2_len",   32'(frame_len), 32'd8);
      check("g2_good",  32'(good_count), 32'd2);

      // Second good sentence without ack: busy drop, old frame kept
      base = wr_addr_log.size();
      send_str("$AB*03\r\n");
      check("busy_addr0", 32'(wr_addr_log[base]), 32'd0);
      check("busy_ready", 32'(frame_ready), 32'd1);
      check("busy_bank",  32'(frame_bank), 32'd1);
      check("busy_len",   32'(frame_len), 32'd8);
      check("busy_drop",  32'(drop_count), 32'd2);
      check("busy_ebz",   32'(n_err_busy), 32'd1);
      check("busy_good",  32'(good_count), 32'd2);

      // Ack coincident with the LF strobe: cleared, then new frame next cycle
      send_str("$AB*03\r");
      data       = 8'h0A;
      data_valid = 1'b1;
      repeat (3) @(negedge clk);
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      check("co_gap",   32'(frame_ready), 32'd0);
      @(negedge clk);
      check("co_ready", 32'(frame_ready), 32'd1);
      check("co_bank",  32'(frame_bank), 32'd0);
      check("co_len",   32'(frame_len), 32'd2);
      check("co_good",  32'(good_count), 32'd3);
      check("co_drop",  32'(drop_count), 32'd2);
      repeat (1) @(negedge clk);
      data_valid = 1'b0;
      repeat (6) @(negedge clk);
      ack_frame();

      // Overflow: 65 body bytes, writes stop at offset 63 of bank 1
      base = wr_addr_log.size();
      send_byte(8'h24);
      for (int i = 0; i < 65; i++) send_byte(8'h58);
      check("ovf_nwr",   32'(wr_addr_log.size() - base), 32'd64);
      check("ovf_last",  32'(wr_addr_log[wr_addr_log.size() - 1]), 32'd127);
      check("ovf_eov",   32'(n_err_ovf), 32'd1);
      check("ovf_drop",  32'(drop_count), 32'd3);
      check("ovf_ready", 32'(frame_ready), 32'd0);
      send_str("$AB*03\r\n");
      check("ovf_idle_ready", 32'(frame_ready), 32'd1);
      check("ovf_idle_bank",  32'(frame_bank), 32'd1);
      check("ovf_idle_len",   32'(frame_len), 32'd2);
      check("ovf_idle_good",  32'(good_count), 32'd4);
      ack_frame();

      // Empty body is a checksum drop
      send_str("$*00\r\n");
      check("emp_ready", 32'(frame_ready), 32'd0);
      check("emp_drop",  32'(drop_count), 32'd4);
      check("emp_ecs",   32'(n_err_csum), 32'd2);

      // '$' inside body restarts the sentence
      send_str("$ZZ$AB*03\r\n");
      check("rs_drop",  32'(drop_count), 32'd5);
      check("rs_ecs",   32'(n_err_csum), 32'd3);
      check("rs_ready", 32'(frame_ready), 32'd1);
      check("rs_bank",  32'(frame_bank), 32'd0);
      check("rs_len",   32'(frame_len), 32'd2);
      check("rs_good",  32'(good_count), 32'd5);
      ack_frame();

      // Held-high strobe yields a single byte
      send_byte(8'h24);
      n0 = wr_addr_log.size();
      data       = 8'h41;
      data_valid = 1'b1;
      repeat (20) @(negedge clk);
      data_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("hold_nwr", 32'(wr_addr_log.size() - n0), 32'd1);
      send_str("B*03\r\n");
      check("hold_ready", 32'(frame_ready), 32'd1);
      check("hold_len",   32'(frame_len), 32'd2);
      check("hold_good",  32'(good_count), 32'd6);
      ack_frame();

      // Reset in the middle of a body
      send_str("$AB");
      rst_n = 1'b0;
      #1;
      check("mr_wr_en", 32'(wr_en), 32'd0);
      check("mr_addr",  32'(wr_addr), 32'd0);
      check("mr_data",  32'(wr_data), 32'd0);
      check("mr_ready", 32'(frame_ready), 32'd0);
      check("mr_len",   32'(frame_len), 32'd0);
      check("mr_good",  32'(good_count), 32'd0);
      check("mr_drop",  32'(drop_count), 32'd0);
      check("mr_err",   32'(err_pulse), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_str("$AB*03\r\n");
      check("post_ready", 32'(frame_ready), 32'd1);
      check("post_bank",  32'(frame_bank), 32'd0);
      check("post_good",  32'(good_count), 32'd1);
      check("post_drop",  32'(drop_count), 32'd0);

      // Every error pulse was a single cycle
      check("err_width", 32'(n_err_long), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
